// File: rtl/pipe_seq_ctrl_pkg.sv
// Shared encodings for the pipeline sequencer: FSM states and the MIPS opcodes
// that the load-use compare needs.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MD_WAIT  = 2'd2
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_RTYPE = 6'b000000;

endpackage

// File: rtl/pipe_seq_ctrl_if.sv
// Pipeline-side signal bundle of the sequencer. stall_cnt exists only when
// PIPE_STALL_CNT_EN is defined.
interface pipe_seq_ctrl_if
`ifdef PIPE_STALL_CNT_EN
  #(parameter int CNT_W = 16)
`endif
  ;
  logic [31:0] id_inst;
  logic [4:0]  id_ex_rd;
  logic        id_ex_memread;
  logic        ex_branch_taken;
  logic        ex_md_req;
  logic        md_done;
  logic        mem_req;
  logic        mem_ready;

  logic        pc_en;
  logic        if_id_en;
  logic        id_ex_en;
  logic        ex_mem_en;
  logic        mem_wb_en;
  logic        if_id_flush;
  logic        id_ex_bubble;
  logic        ex_mem_bubble;
  logic        md_start;
  logic        md_timeout;
  logic [1:0]  state_o;
`ifdef PIPE_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt;
`endif

  modport slave (
    input  id_inst, id_ex_rd, id_ex_memread, ex_branch_taken,
           ex_md_req, md_done, mem_req, mem_ready,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_bubble, ex_mem_bubble,
           md_start, md_timeout, state_o
`ifdef PIPE_STALL_CNT_EN
    , output stall_cnt
`endif
  );

  modport master (
    output id_inst, id_ex_rd, id_ex_memread, ex_branch_taken,
           ex_md_req, md_done, mem_req, mem_ready,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_bubble, ex_mem_bubble,
           md_start, md_timeout, state_o
`ifdef PIPE_STALL_CNT_EN
    , input stall_cnt
`endif
  );

endinterface

// File: rtl/pipe_seq_ctrl_luh_detect.sv
// Combinational load-use hazard compare between the load in ID/EX and the
// source registers of the instruction in IF/ID.
module luh_detect
  import pipe_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic [4:0] id_ex_rd,
  input  logic       id_ex_memread,
  output logic       luh
);

  logic rt_used;

  // rt is a source only for R-type, beq, bne and sw; elsewhere it is a destination
  assign rt_used = (opcode == OP_RTYPE) || (opcode == OP_BEQ) ||
                   (opcode == OP_BNE)   || (opcode == OP_SW);

  assign luh = id_ex_memread && (id_ex_rd != 5'd0) &&
               ((id_ex_rd == rs) || ((id_ex_rd == rt) && rt_used));

endmodule

// File: rtl/pipe_seq_ctrl.sv
// Pipeline sequencer: stage enables, flushes and bubbles from memory wait,
// mult/div, taken branch and load-use. Optional stall counter: PIPE_STALL_CNT_EN.
module pipe_seq_ctrl
  import pipe_pkg::*;
#(
  parameter int MD_MAX_CYCLES = 64
`ifdef PIPE_STALL_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  pipe_seq_ctrl_if.slave  bus
);

  localparam logic [7:0] MD_MAX = 8'(MD_MAX_CYCLES);

  state_t     state_reg, state_next;
  logic [7:0] md_cnt_reg, md_cnt_next, md_inc;
  logic       md_start_reg, md_timeout_reg, md_timeout_next;
  logic       md_issued_reg, md_issued_next;
  logic       done_pend_reg, done_pend_next;
  logic       start_now, mem_stall, luh, use_run;
  logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic       if_id_flush, id_ex_bubble, ex_mem_bubble;

  luh_detect u_luh (
    .opcode        (bus.id_inst[31:26]),
    .rs            (bus.id_inst[25:21]),
    .rt            (bus.id_inst[20:16]),
    .id_ex_rd      (bus.id_ex_rd),
    .id_ex_memread (bus.id_ex_memread),
    .luh           (luh)
  );

  assign mem_stall = bus.mem_req && !bus.mem_ready;
  assign md_inc    = (md_cnt_reg == 8'hff) ? md_cnt_reg : md_cnt_reg + 8'd1;

  always_comb begin
    state_next      = state_reg;
    md_cnt_next     = md_cnt_reg;
    md_timeout_next = md_timeout_reg;
    done_pend_next  = done_pend_reg;
    start_now       = 1'b0;
    use_run         = 1'b0;
    pc_en = 1'b0; if_id_en = 1'b0; id_ex_en = 1'b0; ex_mem_en = 1'b0; mem_wb_en = 1'b0;
    if_id_flush = 1'b0; id_ex_bubble = 1'b0; ex_mem_bubble = 1'b0;

    case (state_reg)
      RUN:      use_run = 1'b1;
      MEM_WAIT: use_run = bus.mem_ready;
      MD_WAIT: begin
        if (mem_stall) begin
          // a done pulse during an overlaid memory stall must not be lost
          if (bus.md_done) done_pend_next = 1'b1;
        end else if (bus.md_done || done_pend_reg) begin
          {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b11111;
          state_next     = RUN;
          md_cnt_next    = 8'd0;
          done_pend_next = 1'b0;
        end else begin
          ex_mem_en     = 1'b1;
          ex_mem_bubble = 1'b1;
          mem_wb_en     = 1'b1;
          md_cnt_next   = md_inc;
          if (md_inc >= MD_MAX) md_timeout_next = 1'b1;
        end
      end
      default: state_next = RUN;
    endcase

    if (use_run) begin
      state_next = RUN;
      if (mem_stall) begin
        state_next = MEM_WAIT;
      end else if (bus.ex_md_req && !md_issued_reg) begin
        ex_mem_en     = 1'b1;
        ex_mem_bubble = 1'b1;
        mem_wb_en     = 1'b1;
        start_now     = 1'b1;
        md_cnt_next   = 8'd0;
        state_next    = MD_WAIT;
      end else if (bus.ex_branch_taken) begin
        {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b11111;
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
      end else if (luh) begin
        {id_ex_en, ex_mem_en, mem_wb_en} = 3'b111;
        id_ex_bubble = 1'b1;
      end else begin
        {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b11111;
      end
    end

    // re-arm only once the mult/div instruction has really left EX
    md_issued_next = md_issued_reg;
    if (start_now)                     md_issued_next = 1'b1;
    else if (ex_mem_en && !ex_mem_bubble) md_issued_next = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= RUN;
      md_cnt_reg     <= 8'd0;
      md_start_reg   <= 1'b0;
      md_timeout_reg <= 1'b0;
      md_issued_reg  <= 1'b0;
      done_pend_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      md_cnt_reg     <= md_cnt_next;
      md_start_reg   <= start_now;
      md_timeout_reg <= md_timeout_next;
      md_issued_reg  <= md_issued_next;
      done_pend_reg  <= done_pend_next;
    end
  end

  assign bus.pc_en         = pc_en && rst_n;
  assign bus.if_id_en      = if_id_en && rst_n;
  assign bus.id_ex_en      = id_ex_en && rst_n;
  assign bus.ex_mem_en     = ex_mem_en && rst_n;
  assign bus.mem_wb_en     = mem_wb_en && rst_n;
  assign bus.if_id_flush   = if_id_flush && rst_n;
  assign bus.id_ex_bubble  = id_ex_bubble && rst_n;
  assign bus.ex_mem_bubble = ex_mem_bubble && rst_n;
  assign bus.md_start      = md_start_reg;
  assign bus.md_timeout    = md_timeout_reg;
  assign bus.state_o       = state_reg;

`ifdef PIPE_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt_reg <= '0;
    else if (!pc_en && (stall_cnt_reg != {CNT_W{1'b1}}))
      stall_cnt_reg <= stall_cnt_reg + 1'b1;
  end

  assign bus.stall_cnt = stall_cnt_reg;
`endif

endmodule
